// File: rtl/subleq_seq_if.sv
// subleq_seq_if: instruction ROM and single-port data memory bus of the SUBLEQ sequencer
interface subleq_seq_if #(
  parameter int A = 8,
  parameter int D = 8,
  parameter int PW = 4
);
  logic [PW-1:0] imem_addr;
  logic [3*A-1:0] imem_rdata;
  logic [A-1:0] dmem_addr;
  logic dmem_we;
  logic [D-1:0] dmem_wdata;
  logic [D-1:0] dmem_rdata;
  modport master (output imem_addr, dmem_addr, dmem_we, dmem_wdata, input imem_rdata, dmem_rdata);
  modport slave (input imem_addr, dmem_addr, dmem_we, dmem_wdata, output imem_rdata, dmem_rdata);
endinterface

// File: rtl/subleq_seq.sv
// subleq_seq: five-cycle SUBLEQ sequencer; mem[b] -= mem[a], branch to c when the result is <= 0
module subleq_seq #(
  parameter int A = 8,
  parameter int D = 8,
  parameter int I_MEM = 16,
  parameter int IO_ADDR = 2**A-1,
  localparam int PW = $clog2(I_MEM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  subleq_seq_if.master mem,
  input  logic [D-1:0] io_in,
  output logic [D-1:0] io_out,
  output logic busy,
  output logic halted,
  output logic [PW-1:0] pc,
  output logic [15:0] retired
);
  localparam int NW = (A > PW ? A : PW) + 1;
  localparam logic [A-1:0] IO = A'(IO_ADDR);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RDA, RDB, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [A-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [D-1:0] va_q, va_d, io_q, io_d, vb, r;
  logic [15:0] ret_q, ret_d;
  logic [NW-1:0] npc;
  logic taken;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      va_q <= '0;
      io_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      va_q <= va_d;
      io_q <= io_d;
      ret_q <= ret_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    va_d = va_q;
    io_d = io_q;
    ret_d = ret_q;
    vb = b_q == IO ? io_in : mem.dmem_rdata;
    r = vb - va_q;
    taken = r == '0 || r[D-1];
    // wide enough to see a branch target or fall-through past the last instruction
    npc = taken ? NW'(c_q) : NW'(pc_q) + NW'(1);
    case (state_q)
      IDLE: if (start) begin
        pc_d = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        {a_d, b_d, c_d} = mem.imem_rdata;
        state_d = RDA;
      end
      RDA: state_d = RDB;
      RDB: begin
        va_d = a_q == IO ? io_in : mem.dmem_rdata;
        state_d = WB;
      end
      WB: begin
        io_d = b_q == IO ? r : io_q;
        ret_d = ret_q == '1 ? ret_q : ret_q + 16'd1;
        state_d = npc >= NW'(I_MEM) ? HALT : FETCH;
        pc_d = npc >= NW'(I_MEM) ? pc_q : npc[PW-1:0];
      end
      HALT: if (start) begin
        pc_d = '0;
        ret_d = '0;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  // memory strobes decode straight from state so an async reset drops them at once
  assign mem.imem_addr = pc_q;
  assign mem.dmem_addr = state_q == RDA ? a_q : (state_q == RDB || state_q == WB) ? b_q : '0;
  assign mem.dmem_we = state_q == WB && b_q != IO;
  assign mem.dmem_wdata = mem.dmem_we ? r : '0;
  assign io_out = io_q;
  assign busy = state_q != IDLE && state_q != HALT;
  assign halted = state_q == HALT;
  assign pc = pc_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_subleq_seq.sv
// tb_subleq_seq: scoreboard bench; an architectural SUBLEQ model predicts writes and retirements
module tb_subleq_seq;
  localparam int A = 8;
  localparam int D = 8;
  localparam int I_MEM = 16;
  localparam int PW = 4;
  typedef struct packed {logic [A-1:0] addr; logic [D-1:0] data;} wr_t;
  typedef struct packed {logic [PW-1:0] pc; logic [D-1:0] io; logic hlt; logic [15:0] ret;} rt_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [D-1:0] io_in = '0, io_out;
  logic busy, halted;
  logic [PW-1:0] pc;
  logic [15:0] retired;
  logic pl_we = 0;
  logic [A-1:0] pl_a = '0;
  logic [D-1:0] pl_d = '0;
  logic [3*A-1:0] imem [I_MEM] = '{default: '0};
  logic [D-1:0] dmem [2**A] = '{default: '0};
  logic [D-1:0] ref_mem [2**A] = '{default: '0};
  logic [D-1:0] ref_io = '0;
  wr_t wq[$];
  rt_t rq[$];
  int n_pass = 0, n_tot = 0;

  subleq_seq_if #(.A(A), .D(D), .PW(PW)) mem ();
  subleq_seq #(.A(A), .D(D), .I_MEM(I_MEM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem(mem), .io_in(io_in), .io_out(io_out),
    .busy(busy), .halted(halted), .pc(pc), .retired(retired));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem.imem_rdata <= imem[mem.imem_addr];
    mem.dmem_rdata <= dmem[mem.dmem_addr];
    if (pl_we) dmem[pl_a] <= pl_d;
    else if (mem.dmem_we) dmem[mem.dmem_addr] <= mem.dmem_wdata;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic logic [3*A-1:0] ins(input int a, input int b, input int c);
    return {A'(a), A'(b), A'(c)};
  endfunction

  function automatic logic [A-1:0] pick();
    return $urandom_range(0, 9) == 0 ? 8'hFF : A'($urandom_range(0, 7));
  endfunction

  // runs the loaded program from pc 0 instruction by instruction, queueing expected effects
  function automatic int model(input logic [D-1:0] io);
    int p = 0;
    int nx;
    logic [A-1:0] a, b, c;
    logic [D-1:0] va, vb, r;
    for (int k = 1; k <= 64; k++) begin
      {a, b, c} = imem[p];
      va = a == 8'hFF ? io : ref_mem[a];
      vb = b == 8'hFF ? io : ref_mem[b];
      r = vb - va;
      if (b == 8'hFF) ref_io = r;
      else begin
        ref_mem[b] = r;
        wq.push_back('{b, r});
      end
      nx = $signed(r) <= 0 ? int'(c) : p + 1;
      if (nx >= I_MEM) begin
        rq.push_back('{PW'(p), ref_io, 1'b1, 16'(k)});
        return k;
      end
      rq.push_back('{PW'(nx), ref_io, 1'b0, 16'(k)});
      p = nx;
    end
    return 64;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [A-1:0] ad, input logic [D-1:0] d);
    pl_we = 1;
    pl_a = ad;
    pl_d = d;
    ref_mem[ad] = d;
    tick(1);
    pl_we = 0;
  endtask

  task automatic go(input logic [D-1:0] io, output int n);
    io_in = io;
    n = model(io);
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_halt(input int n, input int done);
    int c = done;
    while (!halted && c < 5 * n + 20) begin
      tick(1);
      c++;
    end
    chk("cycles", c, 5 * n);
    @(negedge clk);
    #1;
    chk("sb_drain", wq.size() + rq.size(), 0);
    tick(1);
  endtask

  initial begin
    logic [15:0] prev;
    wr_t w;
    rt_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mem.dmem_we) begin
        if (wq.size() == 0) begin
          n_tot++;
          $display("FAIL unexp_write: addr %0h data %0h with nothing expected", mem.dmem_addr, mem.dmem_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", mem.dmem_addr, w.addr);
          chk("wr_data", mem.dmem_wdata, w.data);
        end
      end
      if (retired == prev + 16'd1) begin
        if (rq.size() == 0) begin
          n_tot++;
          $display("FAIL unexp_retire: retired %0d with nothing expected", retired);
        end else begin
          e = rq.pop_front();
          chk("ret_pc", pc, e.pc);
          chk("ret_io", io_out, e.io);
          chk("ret_halt", halted, e.hlt);
          chk("ret_cnt", retired, e.ret);
        end
      end
      prev = retired;
    end
  end

  initial begin
    int n;
    logic sw, sb;
    tick(1);
    start = 1;
    tick(1);
    start = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_io_out", io_out, 0);
    chk("rst_we", mem.dmem_we, 0);
    chk("rst_daddr", mem.dmem_addr, 0);
    chk("rst_wdata", mem.dmem_wdata, 0);
    chk("rst_iaddr", mem.imem_addr, 0);
    tick(1);
    rst_n = 1;
    sw = 0;
    sb = 0;
    repeat (10) begin
      @(negedge clk);
      sw |= mem.dmem_we;
      sb |= busy;
    end
    chk("idle_we", sw, 0);
    chk("idle_busy", sb, 0);
    tick(1);

    poke(10, 8'h03); poke(11, 8'h05); poke(12, 8'hA5);
    imem[0] = ins(10, 11, 7);
    imem[1] = ins(12, 12, 255);
    go(8'h00, n);
    tick(4);
    chk("c5_we", mem.dmem_we, 1);
    chk("c5_addr", mem.dmem_addr, 11);
    chk("c5_data", mem.dmem_wdata, 8'h02);
    wait_halt(n, 4);
    chk("nt_mem11", dmem[11], 8'h02);
    chk("nt_pc", pc, 1);

    poke(10, 8'h05); poke(11, 8'h05);
    imem[0] = ins(10, 11, 7);
    imem[7] = ins(12, 12, 255);
    go(8'h00, n);
    wait_halt(n, 0);
    chk("tk_mem11", dmem[11], 8'h00);
    chk("tk_pc", pc, 7);

    poke(1, 8'h01); poke(2, 8'h00); poke(3, 8'h01); poke(4, 8'h80);
    imem[0] = ins(1, 2, 9);
    imem[9] = ins(3, 4, 255);
    imem[10] = ins(5, 5, 255);
    go(8'h00, n);
    wait_halt(n, 0);
    chk("sg_neg", dmem[2], 8'hFF);
    chk("sg_pos", dmem[4], 8'h7F);
    chk("sg_pc", pc, 10);

    poke(20, 8'h0C);
    imem[0] = ins(255, 20, 255);
    imem[1] = ins(0, 0, 255);
    go(8'h09, n);
    wait_halt(n, 0);
    chk("io_rd", dmem[20], 8'h03);

    imem[0] = ins(20, 255, 255);
    go(8'h05, n);
    sw = 0;
    repeat (5) begin
      @(negedge clk);
      sw |= mem.dmem_we;
    end
    tick(1);
    chk("io_no_we", sw, 0);
    wait_halt(n, 5);
    chk("io_out", io_out, 8'h02);

    poke(1, 8'h01); poke(2, 8'h03);
    imem[0] = ins(0, 0, 15);
    imem[15] = ins(1, 2, 3);
    go(8'h00, n);
    wait_halt(n, 0);
    chk("end_pc", pc, 15);
    chk("end_halted", halted, 1);

    go(8'h00, n);
    chk("rs_pc", pc, 0);
    chk("rs_retired", retired, 0);
    chk("rs_busy", busy, 1);
    chk("rs_halted", halted, 0);
    tick(3);
    start = 1;
    tick(1);
    start = 0;
    wait_halt(n, 4);
    chk("rs_pc_end", pc, 15);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++) poke(A'(i), D'($urandom));
      for (int p = 0; p < I_MEM; p++)
        imem[p] = {pick(), pick(), (p < I_MEM - 1 && $urandom_range(0, 1) == 1) ?
                   A'($urandom_range(I_MEM - 1, p + 1)) : A'($urandom_range(255, I_MEM))};
      go(D'($urandom), n);
      wait_halt(n, 0);
    end

    poke(20, 8'h10); poke(21, 8'h33);
    imem[0] = ins(20, 255, 255);
    imem[1] = ins(20, 21, 255);
    go(8'h50, n);
    tick(9);
    chk("pre_we", mem.dmem_we, 1);
    chk("pre_io", io_out, 8'h40);
    rst_n = 0;
    #1;
    chk("ar_we", mem.dmem_we, 0);
    chk("ar_busy", busy, 0);
    chk("ar_halted", halted, 0);
    chk("ar_io_out", io_out, 0);
    chk("ar_pc", pc, 0);
    wq.delete();
    rq.delete();
    tick(1);
    chk("ar_no_write", dmem[21], 8'h33);
    rst_n = 1;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
